// File: rtl/la_chkmon_pkg.sv
// Shared state encoding and failure codes for the LA checkpoint monitor.
package la_chkmon_pkg;

   typedef logic [1:0] chk_state_t;

   localparam chk_state_t ST_IDLE = 2'd0;
   localparam chk_state_t ST_RUN  = 2'd1;
   localparam chk_state_t ST_PASS = 2'd2;
   localparam chk_state_t ST_FAIL = 2'd3;

   localparam logic [1:0] FAIL_NONE  = 2'b00;
   localparam logic [1:0] FAIL_TMO   = 2'b01;
   localparam logic [1:0] FAIL_UNEXP = 2'b10;
   localparam logic [1:0] FAIL_CFG   = 2'b11;

endpackage

// File: rtl/la_chkmon_sync_stable.sv
// Input synchronizer plus glitch filter: flags the first cycle a synced value has held
// for STABLE_CYC consecutive cycles.
module la_chkmon_sync_stable #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned STABLE_CYC  = 2
) (
   input  logic             clock,
   input  logic             resetb,
   input  logic [WIDTH-1:0] status_in,
   output logic [WIDTH-1:0] sync_val,
   output logic             episode_start,
   output logic [WIDTH-1:0] stable_val
);

   localparam int unsigned CW = $clog2(STABLE_CYC + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] stable_q;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic             changed;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= status_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync_val = sync_q[SYNC_STAGES-1];
   assign changed  = (sync_val != prev_q);

   always_comb begin
      cnt_d = cnt_q;
      if (changed) begin
         cnt_d = CW'(1);
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // The change term lets STABLE_CYC == 1 start an episode on every new value.
   assign episode_start = (cnt_d == CNT_MAX) && (changed || (cnt_q != CNT_MAX));
   assign stable_val    = stable_q;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         prev_q   <= '0;
         cnt_q    <= '0;
         stable_q <= '0;
      end else begin
         prev_q <= sync_val;
         cnt_q  <= cnt_d;
         if (episode_start) stable_q <= sync_val;
      end
   end

endmodule

// File: rtl/la_checkpoint_monitor.sv
// Steps through a programmed table of expected status values, reporting pass, fail and
// progress; table, run FSM and inter-hit timeout live here.
module la_checkpoint_monitor
   import la_chkmon_pkg::*;
#(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned TMO_W       = 20,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned STABLE_CYC  = 2
) (
   input  logic                       clock,
   input  logic                       resetb,
   input  logic                       prog_we,
   input  logic [$clog2(DEPTH)-1:0]   prog_addr,
   input  logic [WIDTH-1:0]           prog_data,
   input  logic [$clog2(DEPTH):0]     num_chk,
   input  logic [TMO_W-1:0]           timeout_cyc,
   input  logic                       strict,
   input  logic                       arm,
   input  logic                       abort,
   input  logic [WIDTH-1:0]           status_in,
   output logic                       busy,
   output logic                       pass,
   output logic                       fail,
   output logic [1:0]                 fail_code,
   output logic [$clog2(DEPTH):0]     chk_idx,
   output logic                       hit_pulse,
   output logic [WIDTH-1:0]           last_val
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned IW = AW + 1;

   logic [WIDTH-1:0] sync_val;
   logic             episode;

   la_chkmon_sync_stable #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_CYC  (STABLE_CYC)
   ) u_sync_stable (
      .clock         (clock),
      .resetb        (resetb),
      .status_in     (status_in),
      .sync_val      (sync_val),
      .episode_start (episode),
      .stable_val    (last_val)
   );

   logic [WIDTH-1:0] tbl_q [DEPTH];
   chk_state_t       state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d, idx_inc;
   logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
   logic [WIDTH-1:0] ref_q, ref_d, expected;
   logic             pass_q, pass_d, fail_q, fail_d, hit_q, hit_d;
   logic [1:0]       code_q, code_d;
   logic             cfg_bad;

   // Table is deliberately not reset so contents survive a mid-run resetb.
   always_ff @(posedge clock) begin
      if (prog_we && (state_q != ST_RUN) && ({1'b0, prog_addr} < IW'(DEPTH))) begin
         tbl_q[prog_addr] <= prog_data;
      end
   end

   assign expected = tbl_q[idx_q[AW-1:0]];
   assign cfg_bad  = (num_chk == '0) || (num_chk > IW'(DEPTH));
   assign idx_inc  = idx_q + IW'(1);
   assign tmo_inc  = (&tmo_q) ? tmo_q : tmo_q + TMO_W'(1);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tmo_d   = tmo_q;
      ref_d   = ref_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      code_d  = code_q;
      hit_d   = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
               idx_d   = '0;
               tmo_d   = '0;
            end else if (episode && (sync_val == expected)) begin
               hit_d = 1'b1;
               idx_d = idx_inc;
               tmo_d = '0;
               ref_d = sync_val;
               if (idx_inc == num_chk) begin
                  state_d = ST_PASS;
                  pass_d  = 1'b1;
               end
            end else if (strict && episode && (sync_val != ref_q)) begin
               state_d = ST_FAIL;
               fail_d  = 1'b1;
               code_d  = FAIL_UNEXP;
            end else begin
               tmo_d = tmo_inc;
               if ((timeout_cyc != '0) && (tmo_inc >= timeout_cyc)) begin
                  state_d = ST_FAIL;
                  fail_d  = 1'b1;
                  code_d  = FAIL_TMO;
               end
            end
         end
         ST_IDLE, ST_PASS, ST_FAIL: begin
            if (arm && !abort) begin
               pass_d = 1'b0;
               fail_d = 1'b0;
               code_d = FAIL_NONE;
               idx_d  = '0;
               tmo_d  = '0;
               ref_d  = sync_val;
               if (cfg_bad) begin
                  state_d = ST_FAIL;
                  fail_d  = 1'b1;
                  code_d  = FAIL_CFG;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         tmo_q   <= '0;
         ref_q   <= '0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         code_q  <= FAIL_NONE;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tmo_q   <= tmo_d;
         ref_q   <= ref_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         code_q  <= code_d;
         hit_q   <= hit_d;
      end
   end

   assign busy      = (state_q == ST_RUN);
   assign pass      = pass_q;
   assign fail      = fail_q;
   assign fail_code = code_q;
   assign chk_idx   = idx_q;
   assign hit_pulse = hit_q;

endmodule
